grf_mp_sb: RTL
==============

Name: grf_mp_sb

Overview:
- Parametrised general register file, successor to the single-write, two-read GRF.
- Adds configurable width and depth, N combinational read ports, two prioritised write ports, and a per-register busy scoreboard for pipeline hazard detection.
- Adds a sequenced post-reset clear with a ready flag.
- Sits in the decode stage: read ports feed operand fetch, write ports come from writeback, and the alloc port is driven at issue.

Parameters:
- WIDTH, 32: data width of each register.
- NUM_REGS, 32: number of registers; power of two, at least 2.
- NUM_RD, 2: number of read ports.
- AW, $clog2(NUM_REGS): address width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- ready  out  1  high once the post-reset clear is complete.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
- rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1; wins over port 0 on the same address.
- wa1  in  AW  write address, port 1.
- wd1  in  WIDTH  write data, port 1.
- alloc_en  in  1  mark register alloc_addr busy.
- alloc_addr  in  AW  register to mark busy.

Behaviour:

FSM states: CLEAR, READY.
- While reset==0 at a clk edge: state<=CLEAR, clr_ptr<=0, all busy bits<=0, ready<=0.
- In CLEAR, each cycle: reg[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
- When clr_ptr==NUM_REGS-1: the entry is cleared, state<=READY, ready<=1.
- Clear therefore takes exactly NUM_REGS cycles after reset is deasserted.
- Reset asserted mid-clear restarts the clear from entry 0.
- In CLEAR:
  - we0, we1 and alloc_en are ignored.
  - rd_data is 0 and rd_busy is 0 on all ports.
- READY is terminal until the next reset.

Writes (READY only):
- Writes take effect at the clk edge.
- Address 0 is hardwired to zero: writes to it are dropped and it never becomes busy.
- we0 and we1 to the same address: wd1 is stored.
- A write clears the busy bit of its address.

Alloc (READY only):
- alloc_en sets busy[alloc_addr] at the clk edge.
- alloc and a write to the same address in the same cycle: data is written, and busy ends at 1 (the new producer wins).

Reads:
- Purely combinational, per port k.
- rd_addr==0 gives rd_data=0 and rd_busy=0.
- Otherwise rd_data=reg[addr] and rd_busy=busy[addr], subject to the bypass rules below.

Widths:
- No arithmetic.
- Pointer clr_ptr is AW bits and wraps only at the CLEAR->READY transition.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined (write-through bypass):
  - In READY, if a port reads a nonzero address being written this cycle, rd_data is the write data (wd1 when both write ports match).
  - rd_busy is 0, unless alloc_en targets the same address in the same cycle, in which case rd_busy is 1.
- Undefined:
  - Reads return the stored value and stored busy bit.
  - The written value and cleared busy bit are visible from the next cycle.

Test Plan:
1. Reset clear: with NUM_REGS=32, preload reg5=0xDEADBEEF, hold reset=0 for 2 cycles, then release.
   -> ready=0 for exactly 32 cycles, then 1; rd_data for address 5 is 0; all rd_busy are 0.
2. Mid-clear reset: assert reset=0 at clear cycle 10, release, and count cycles.
   -> ready rises 32 cycles after the second release; we0 writes issued during the clear are not stored.
3. Dual-write collision: in READY, we0 (wa0=7, wd0=0x11) and we1 (wa1=7, wd1=0x22) in the same cycle.
   -> the next cycle, a read of 7 returns 0x22.
   -> a write of 0x55 to address 0 reads back 0.
4. Scoreboard: alloc 9, then next cycle alloc 9 together with we0 to 9 (0x33); then a lone we1 to 9 (0x44).
   -> rd_busy for 9 is 1 after the first and second cycles, and 0 after the third.
   -> data is 0x33 after the second cycle and 0x44 after the third.
5. Bypass, NUM_RD=3, GRF_BYPASS_EN defined: reg3=0x1, port 2 reads 3 while we1 writes 3 with 0xABCD.
   -> same-cycle rd_data on port 2 is 0xABCD and rd_busy is 0.
   -> with the macro undefined, the same cycle returns 0x1 and the next cycle returns 0xABCD.
6. Parameter sweep: WIDTH=16, NUM_REGS=8, random writes, allocs and reads against a reference model.
   -> clear takes 8 cycles; all reads match the model; address 0 always reads 0 with rd_busy=0.

Source files
------------

// File: rtl/grf_mp_sb.sv
// Multi-port general register file with a busy scoreboard and a sequenced post-reset clear.
// Optional macro GRF_BYPASS_EN forwards same-cycle write data to the read ports.
module grf_mp_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [AW-1:0]            wa0,
    input  logic [WIDTH-1:0]         wd0,
    input  logic                     we1,
    input  logic [AW-1:0]            wa1,
    input  logic [WIDTH-1:0]         wd1,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                state_q;
    logic [AW-1:0]         clr_ptr_q;
    logic [WIDTH-1:0]      regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            busy_q    <= '0;
            ready     <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    regs_q[clr_ptr_q] <= '0;
                    clr_ptr_q         <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == AW'(NUM_REGS - 1)) begin
                        state_q <= StReady;
                        ready   <= 1'b1;
                    end
                end
                StReady: begin
                    // Port 1 is applied last so it wins an address collision.
                    if (we0 && wa0 != '0) begin
                        regs_q[wa0] <= wd0;
                        busy_q[wa0] <= 1'b0;
                    end
                    if (we1 && wa1 != '0) begin
                        regs_q[wa1] <= wd1;
                        busy_q[wa1] <= 1'b0;
                    end
                    // A new producer issued alongside a writeback keeps the register busy.
                    if (alloc_en && alloc_addr != '0) begin
                        busy_q[alloc_addr] <= 1'b1;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (state_q == StReady && addr != '0) begin
                data = regs_q[addr];
                busy = busy_q[addr];
`ifdef GRF_BYPASS_EN
                if (we1 && wa1 == addr) begin
                    data = wd1;
                    busy = alloc_en && alloc_addr == addr;
                end else if (we0 && wa0 == addr) begin
                    data = wd0;
                    busy = alloc_en && alloc_addr == addr;
                end
`endif
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = data;
        assign rd_busy[k]                = busy;
    end

endmodule
